// File: rtl/text_write_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : text_write_ctrl_pkg                                          |
// | Description : Shared geometry, character codes and encodings for the text  |
// |               write sequencer.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package text_write_ctrl_pkg;

  localparam int DEF_COLS  = 80;
  localparam int DEF_ROWS  = 60;
  localparam int DEF_COL_W = 7;
  localparam int DEF_ROW_W = 6;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLR_LINE = 2'd1;
  localparam logic [1:0] ST_CLR_ALL  = 2'd2;

  typedef enum logic [2:0] {
    OP_PRINT = 3'd0,
    OP_CR    = 3'd1,
    OP_LF    = 3'd2,
    OP_BS    = 3'd3,
    OP_FF    = 3'd4,
    OP_NOP   = 3'd5
  } byte_op_e;

  function automatic byte_op_e decode_byte(input logic [7:0] b);
    byte_op_e op;
    if (b >= CH_SPACE) begin
      op = OP_PRINT;
    end else begin
      case (b)
        CH_CR:   op = OP_CR;
        CH_LF:   op = OP_LF;
        CH_BS:   op = OP_BS;
        CH_FF:   op = OP_FF;
        default: op = OP_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter2                                                  |
// | Description : Two-way round-robin arbiter; history moves only on accept.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_last_b;
  logic w_grant_b;

  // With no request pending the grant parks on the requester served least recently.
  always_comb begin
    if (req[0] ^ req[1]) w_grant_b = req[1];
    else                 w_grant_b = ~r_last_b;
  end

  assign grant = {w_grant_b, ~w_grant_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_last_b <= 1'b1;
    else if (accept) r_last_b <= w_grant_b;
  end

endmodule

`default_nettype wire

// File: rtl/text_write_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : text_write_ctrl                                              |
// | Description : Arbitrates two byte streams, owns the cursor and issues      |
// |               single-cell writes plus line / screen clear sweeps.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module text_write_ctrl
  import text_write_ctrl_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  output logic             b_ready,
  input  logic             clear_req,
  output logic             busy,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic [7:0]       wr_data,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [COL_W-1:0] r_sw_col, w_sw_col_nxt;
  logic [ROW_W-1:0] r_sw_row, w_sw_row_nxt;
  logic [COL_W-1:0] r_cur_col, w_cur_col_nxt;
  logic [ROW_W-1:0] r_cur_row, w_cur_row_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [COL_W-1:0] r_wr_col, w_wr_col_nxt;
  logic [ROW_W-1:0] r_wr_row, w_wr_row_nxt;
  logic [7:0]       r_wr_data, w_wr_data_nxt;

  logic [1:0] w_grant;
  logic       w_accept_ok;
  logic       w_xfer;
  logic [7:0] w_byte;
  byte_op_e   w_op;
  logic       w_newline;
  logic       w_start_all;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_valid, a_valid}),
    .accept  (w_xfer),
    .grant   (w_grant)
  );

  assign w_accept_ok = (r_state == ST_IDLE) & ~clear_req;
  assign a_ready     = w_accept_ok & w_grant[0];
  assign b_ready     = w_accept_ok & w_grant[1];
  assign w_xfer      = (a_valid & a_ready) | (b_valid & b_ready);
  assign w_byte      = w_grant[1] ? b_data : a_data;
  assign w_op        = decode_byte(w_byte);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CLR_ALL;
      r_sw_col  <= '0;
      r_sw_row  <= '0;
      r_cur_col <= '0;
      r_cur_row <= '0;
      r_wr_en   <= 1'b0;
      r_wr_col  <= '0;
      r_wr_row  <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sw_col  <= w_sw_col_nxt;
      r_sw_row  <= w_sw_row_nxt;
      r_cur_col <= w_cur_col_nxt;
      r_cur_row <= w_cur_row_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_col  <= w_wr_col_nxt;
      r_wr_row  <= w_wr_row_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sw_col_nxt  = r_sw_col;
    w_sw_row_nxt  = r_sw_row;
    w_cur_col_nxt = r_cur_col;
    w_cur_row_nxt = r_cur_row;
    w_newline     = 1'b0;
    w_start_all   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_start_all = 1'b1;
        end else if (w_xfer) begin
          case (w_op)
            OP_PRINT: begin
              if (r_cur_col == LAST_COL) w_newline = 1'b1;
              else                       w_cur_col_nxt = r_cur_col + 1'b1;
            end
            OP_CR:   w_cur_col_nxt = '0;
            OP_LF:   w_newline = 1'b1;
            OP_BS:   if (r_cur_col != '0) w_cur_col_nxt = r_cur_col - 1'b1;
            OP_FF:   w_start_all = 1'b1;
            default: ;
          endcase
        end
      end
      ST_CLR_LINE: begin
        if (clear_req)                  w_start_all = 1'b1;
        else if (r_sw_col == LAST_COL)  w_state_nxt = ST_IDLE;
        else                            w_sw_col_nxt = r_sw_col + 1'b1;
      end
      ST_CLR_ALL: begin
        if (clear_req) begin
          w_start_all = 1'b1;
        end else if (r_sw_col == LAST_COL) begin
          w_sw_col_nxt = '0;
          if (r_sw_row == LAST_ROW) w_state_nxt  = ST_IDLE;
          else                      w_sw_row_nxt = r_sw_row + 1'b1;
        end else begin
          w_sw_col_nxt = r_sw_col + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The line sweep reuses the cursor row, which is already the freshly entered row.
    if (w_newline) begin
      w_cur_col_nxt = '0;
      w_cur_row_nxt = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + 1'b1;
      w_sw_col_nxt  = '0;
      w_state_nxt   = ST_CLR_LINE;
    end
    if (w_start_all) begin
      w_cur_col_nxt = '0;
      w_cur_row_nxt = '0;
      w_sw_col_nxt  = '0;
      w_sw_row_nxt  = '0;
      w_state_nxt   = ST_CLR_ALL;
    end
  end

  // A clear request during a sweep suppresses that cycle's write; the sweep restarts anyway.
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_col_nxt  = '0;
    w_wr_row_nxt  = '0;
    w_wr_data_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_op == OP_PRINT) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_col_nxt  = r_cur_col;
          w_wr_row_nxt  = r_cur_row;
          w_wr_data_nxt = w_byte;
        end else if (w_xfer && w_op == OP_BS && r_cur_col != '0) begin
          w_wr_en_nxt  = 1'b1;
          w_wr_col_nxt = r_cur_col - 1'b1;
          w_wr_row_nxt = r_cur_row;
        end
      end
      ST_CLR_LINE: begin
        if (!clear_req) begin
          w_wr_en_nxt  = 1'b1;
          w_wr_col_nxt = r_sw_col;
          w_wr_row_nxt = r_cur_row;
        end
      end
      ST_CLR_ALL: begin
        if (!clear_req) begin
          w_wr_en_nxt  = 1'b1;
          w_wr_col_nxt = r_sw_col;
          w_wr_row_nxt = r_sw_row;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != ST_IDLE);
  assign wr_en   = r_wr_en;
  assign wr_col  = r_wr_col;
  assign wr_row  = r_wr_row;
  assign wr_data = r_wr_data;
  assign cur_col = r_cur_col;
  assign cur_row = r_cur_row;

endmodule

`default_nettype wire

// File: tb/tb_text_write_ctrl.sv
// Testbench for text_write_ctrl: directed scenarios plus random traffic, checked
// against a character-screen model driven by the accepted byte stream.
`timescale 1ns/1ps
`default_nettype none

module tb_text_write_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ready, b_ready, busy, wr_en;
  logic [6:0] wr_col, cur_col;
  logic [5:0] wr_row, cur_row;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_scr  [ROWS][COLS];
  logic [7:0] shadow [ROWS][COLS];
  int  mc = 0, mr = 0;
  bit  m_last_b = 1'b1;
  bit  last_acc_b;

  text_write_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .clear_req(clear_req), .busy(busy),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_scr[r][c] = 8'h00;
    mc = 0;
    mr = 0;
  endtask

  task automatic m_newline();
    mc = 0;
    mr = (mr + 1) % ROWS;
    for (int c = 0; c < COLS; c++) m_scr[mr][c] = 8'h00;
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b >= 8'h20) begin
      m_scr[mr][mc] = b;
      if (mc == COLS - 1) m_newline();
      else mc++;
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        m_scr[mr][mc] = 8'h00;
      end
    end else if (b == 8'h0C) begin
      m_clear_all();
    end
  endtask

  // One clock: judge the handshake just before the edge, the registered result just after.
  task automatic tick();
    logic acc_a, acc_b, clr, was_busy, exp_en;
    logic [7:0] b;
    int oc, orow, exp_c;
    #2;
    acc_a    = a_valid & a_ready;
    acc_b    = b_valid & b_ready;
    clr      = clear_req;
    was_busy = busy;
    if (!was_busy && !clr && (a_valid || b_valid)) begin
      chk("idle_accept", {31'd0, acc_a ^ acc_b}, 32'd1);
      if (a_valid && b_valid) chk("rr_grant", {31'd0, acc_b}, {31'd0, ~m_last_b});
    end
    oc = mc;
    orow = mr;
    b = acc_b ? b_data : a_data;
    exp_en = (acc_a | acc_b) && ((b >= 8'h20) || (b == 8'h08 && oc > 0));
    exp_c  = (b >= 8'h20) ? oc : oc - 1;
    if (clr) m_clear_all();
    else if (acc_a || acc_b) begin
      m_last_b = acc_b;
      m_apply(b);
    end
    last_acc_b = acc_b;
    @(posedge clk);
    #1;
    if (wr_en === 1'b1 && int'(wr_row) < ROWS && int'(wr_col) < COLS)
      shadow[wr_row][wr_col] = wr_data;
    if (acc_a || acc_b) begin
      chk("acc_wr_en", {31'd0, wr_en}, {31'd0, exp_en});
      if (exp_en) begin
        chk("acc_wr_col", wr_col, exp_c);
        chk("acc_wr_row", wr_row, orow);
        chk("acc_wr_data", wr_data, (b >= 8'h20) ? b : 8'h00);
      end
    end
    if (acc_a || acc_b || clr) begin
      chk("cur_col", cur_col, mc);
      chk("cur_row", cur_row, mr);
    end
  endtask

  task automatic send(input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    tick();
    a_valid = 1'b0;
  endtask

  // Counts sweep writes until busy drops; row_fixed < 0 means a row-major full sweep.
  task automatic wait_sweep(input string tag, input int exp_n, input int row_fixed);
    int n, bad, ec, er;
    n = 0;
    bad = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (wr_en === 1'b1) begin
        ec = n % COLS;
        er = (row_fixed >= 0) ? row_fixed : n / COLS;
        if (int'(wr_col) != ec || int'(wr_row) != er || wr_data !== 8'h00) bad++;
        n++;
      end
      if (busy === 1'b0) break;
    end
    chk({tag, "_count"}, n, exp_n);
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 6)  return 8'h0A;
    if (r < 12) return 8'h0D;
    if (r < 22) return 8'h08;
    if (r < 25) return 8'($urandom_range(1, 7));
    return 8'($urandom_range(32, 255));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int src [6];
    int diffs;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_scr[r][c]  = 8'h00;
        shadow[r][c] = 8'hEE;
      end

    // Reset values, even with both requesters asserting.
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_col", wr_col, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_cur", {cur_row, cur_col}, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset_n = 1'b1;
    wait_sweep("init", COLS * ROWS, -1);
    chk("init_a_ready", {31'd0, a_ready}, 32'd1);
    chk("init_b_ready", {31'd0, b_ready}, 32'd0);

    // "HI" on consecutive cycles.
    a_valid = 1'b1;
    a_data  = 8'h48;
    tick();
    a_data  = 8'h49;
    tick();
    a_valid = 1'b0;
    chk("hi_cur_col", cur_col, 2);

    // Both requesters continuously valid: strict alternation.
    a_valid = 1'b1; a_data = 8'h41;
    b_valid = 1'b1; b_data = 8'h42;
    for (int i = 0; i < 6; i++) begin
      tick();
      src[i] = int'(last_acc_b);
    end
    b_valid = 1'b0;
    a_valid = 1'b0;
    for (int i = 1; i < 6; i++) chk("alternate", src[i], 1 - src[i-1]);

    // Walk to the last column, then wrap with a printable.
    for (int i = 0; i < 100 && cur_col != 7'd79; i++) send(8'h2E);
    chk("edge_col", cur_col, 79);
    send(8'h5A);
    chk("wrap_wr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 6'd0, 7'd79, 8'h5A});
    chk("wrap_cur", {cur_row, cur_col}, {6'd1, 7'd0});
    wait_sweep("wrap_line", COLS, 1);

    // Row wrap via LF from the last row.
    for (int i = 0; i < 70 && cur_row != 6'd59; i++) begin
      send(8'h0A);
      wait_sweep("lf_walk", COLS, int'(cur_row));
    end
    chk("last_row", cur_row, 59);
    repeat (5) send(8'h78);
    send(8'h0A);
    chk("lf_wrap_cur", {cur_row, cur_col}, 0);
    wait_sweep("lf_wrap_line", COLS, 0);
    send(8'h08);
    chk("bs_col0_wr_en", {31'd0, wr_en}, 32'd0);
    send(8'h41); send(8'h42); send(8'h43);
    send(8'h08);
    chk("bs_wr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 6'd0, 7'd2, 8'h00});
    chk("bs_cur", {cur_row, cur_col}, {6'd0, 7'd2});

    // clear_req alongside a valid byte: byte held through the sweep.
    a_valid = 1'b1; a_data = 8'h51; clear_req = 1'b1;
    #2;
    chk("clr_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    clear_req = 1'b0;
    wait_sweep("clr_hold", COLS * ROWS, -1);
    tick();
    a_valid = 1'b0;
    chk("held_byte_wr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 6'd0, 7'd0, 8'h51});

    // clear_req ten cycles into a line sweep.
    send(8'h0A);
    repeat (10) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_sweep("abort_line", COLS * ROWS, -1);

    // Form feed, then asynchronous reset mid-sweep.
    send(8'h41);
    send(8'h0C);
    chk("ff_busy", {31'd0, busy}, 32'd1);
    repeat (100) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_cur", {cur_row, cur_col}, 0);
    m_clear_all();
    m_last_b = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_sweep("post_reset", COLS * ROWS, -1);

    // Random traffic from both requesters.
    for (int i = 0; i < 800; i++) begin
      a_valid = ($urandom_range(0, 99) < 60);
      b_valid = ($urandom_range(0, 99) < 50);
      a_data  = rand_byte();
      b_data  = rand_byte();
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
    chk("final_idle", {31'd0, busy}, 32'd0);
    diffs = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (shadow[r][c] !== m_scr[r][c]) diffs++;
    chk("screen_diffs", diffs, 0);
    chk("final_cur", {cur_row, cur_col}, {6'(mr), 7'(mc)});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
